// File: rtl/ori_hist_pkg.sv
// Shared constants and types for the orientation-histogram accumulator.
package ori_hist_pkg;

    localparam int WIN_DIM   = 16;
    localparam int N_BINS    = 32;
    localparam int BIN_W     = 5;
    localparam int ADDR_W    = 8;
    localparam int N_SAMPLES = WIN_DIM * WIN_DIM;

    typedef logic [BIN_W-1:0]  bin_idx_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Window lifecycle: clear bins, collect 256 samples, find the peak, report it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/hist_peak_scan.sv
// Sequential 32-entry maximum search. The parent presents the bin value
// addressed by idx_o each cycle while go_i is high. On ties the earliest
// index is kept because a candidate must be strictly greater to win.
// The final result is latched on the last step and held until the next scan.
module hist_peak_scan
    import ori_hist_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [ACC_W-1:0] bin_val_i,
    output bin_idx_t         idx_o,
    output bin_idx_t         peak_bin_o,
    output logic [ACC_W-1:0] peak_val_o,
    output logic             fin_o
);

    bin_idx_t         idx_q, idx_d;
    bin_idx_t         max_bin_q, max_bin_d;
    logic [ACC_W-1:0] max_val_q, max_val_d;
    bin_idx_t         peak_bin_q, peak_bin_d;
    logic [ACC_W-1:0] peak_val_q, peak_val_d;
    logic             take;

    // Next running maximum; the first entry always seeds it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        idx_d      = idx_q;
        max_bin_d  = max_bin_q;
        max_val_d  = max_val_q;
        peak_bin_d = peak_bin_q;
        peak_val_d = peak_val_q;
        fin_o      = 1'b0;
        take       = (idx_q == '0) || (bin_val_i > max_val_q);
        if (go_i) begin
            idx_d = idx_q + 1'b1;
            if (take) begin
                max_bin_d = idx_q;
                max_val_d = bin_val_i;
            end
            if (idx_q == '1) begin
                fin_o      = 1'b1;
                peak_bin_d = max_bin_d;
                peak_val_d = max_val_d;
            end
        end
    end

    // Scan index, running maximum and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            max_bin_q  <= '0;
            max_val_q  <= '0;
            peak_bin_q <= '0;
            peak_val_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            idx_q      <= idx_d;
            max_bin_q  <= max_bin_d;
            max_val_q  <= max_val_d;
            peak_bin_q <= peak_bin_d;
            peak_val_q <= peak_val_d;
        end
    end

    assign idx_o      = idx_q;
    assign peak_bin_o = peak_bin_q;
    assign peak_val_o = peak_val_q;

endmodule

// File: rtl/ori_hist32_acc.sv
// Orientation-histogram accumulator. Sweeps a 16x16 window in raster order,
// drives the external direction ROM with the awaited sample's address, adds
// each accepted magnitude into the bin the ROM selects (saturating), then
// scans the 32 bins for the dominant orientation.
module ori_hist32_acc
    import ori_hist_pkg::*;
#(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    output addr_t            rom_addr,
    input  bin_idx_t         rom_dir,
    output logic             done,
    output bin_idx_t         peak_bin,
    output logic [ACC_W-1:0] peak_val
);

    state_e           state_q, state_d;
    addr_t            cnt_q, cnt_d;
    logic [ACC_W-1:0] bins_q [N_BINS];
    logic             accept;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    bin_idx_t         scan_idx;
    logic             scan_go;
    logic             scan_fin;

    // in_ready depends on state only, so there is no path from in_valid.
    assign in_ready = (state_q == ACCUM);
    assign accept   = in_ready && in_valid;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign rom_addr = cnt_q;
    assign scan_go  = (state_q == SCAN);

    // Window lifecycle next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = ACCUM;
            ACCUM:   if (accept && (cnt_q == '1)) state_d = SCAN;
            SCAN:    if (scan_fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Raster counter {row, col}: cleared per window, advanced per accepted sample.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CLEAR) cnt_d = '0;
        else if (accept)      cnt_d = cnt_q + 1'b1;
    end

    // Raster counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Saturating bin update: a carry out of ACC_W bits clamps to all-ones.
    always_comb begin
        sum_wide = {1'b0, bins_q[rom_dir]} + {{(ACC_W + 1 - MAG_W){1'b0}}, in_mag};
        sum_sat  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end

    // Histogram bins: zeroed on reset and per window, one bin written per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bins are a flop array, not RAM, so an async clear is legal and required here.
            for (int i = 0; i < N_BINS; i++) bins_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            for (int i = 0; i < N_BINS; i++) bins_q[i] <= '0;
        end else if (accept) begin
            bins_q[rom_dir] <= sum_sat;
        end
    end

    hist_peak_scan #(
        .ACC_W (ACC_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .go_i       (scan_go),
        .bin_val_i  (bins_q[scan_idx]),
        .idx_o      (scan_idx),
        .peak_bin_o (peak_bin),
        .peak_val_o (peak_val),
        .fin_o      (scan_fin)
    );

endmodule

// File: tb/tb_ori_hist32_acc.sv
// Self-checking bench: two instances (ACC_W=16 and ACC_W=12) run in lockstep
// against a cycle-timeline model whose histogram/peak is computed with plain
// arithmetic over the recorded samples.
module tb_ori_hist32_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_mag = '0;

    logic        busy16, ready16, done16, busy12, ready12, done12;
    logic [7:0]  addr16, addr12;
    logic [4:0]  dir16, dir12, pbin16, pbin12;
    logic [15:0] pval16;
    logic [11:0] pval12;

    logic [4:0] rom_tab [256];
    logic [7:0] mag_tab [256];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    assign dir16 = rom_tab[addr16];
    assign dir12 = rom_tab[addr12];

    ori_hist32_acc #(.MAG_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .busy(busy16), .in_valid(in_valid),
        .in_ready(ready16), .in_mag(in_mag), .rom_addr(addr16), .rom_dir(dir16),
        .done(done16), .peak_bin(pbin16), .peak_val(pval16));

    ori_hist32_acc #(.MAG_W(8), .ACC_W(12)) dut12 (
        .clk(clk), .rst(rst), .start(start), .busy(busy12), .in_valid(in_valid),
        .in_ready(ready12), .in_mag(in_mag), .rom_addr(addr12), .rom_dir(dir12),
        .done(done12), .peak_bin(pbin12), .peak_val(pval12));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_busy = 0, m_clear = 0, m_ready = 0, m_done = 0, m_left = 0;
    int m_cnt = 0, m_nacc = 0;
    int s_mag [256];
    int s_dir [256];
    int m_exp_bin16 = 0, m_exp_val16 = 0, m_exp_bin12 = 0, m_exp_val12 = 0;
    int m_hold_bin16 = 0, m_hold_val16 = 0, m_hold_bin12 = 0, m_hold_val12 = 0;

    function automatic void ref_peak(input int w, output int pb, output int pv);
        int h [32];
        int lim;
        lim = (1 << w) - 1;
        for (int b = 0; b < 32; b++) h[b] = 0;
        for (int s = 0; s < 256; s++) begin
            h[s_dir[s]] += s_mag[s];
            if (h[s_dir[s]] > lim) h[s_dir[s]] = lim;
        end
        pb = 0;
        pv = h[0];
        for (int b = 1; b < 32; b++)
            if (h[b] > pv) begin pb = b; pv = h[b]; end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_clear = 0; m_ready = 0; m_done = 0; m_left = 0;
            m_cnt = 0; m_nacc = 0;
            m_hold_bin16 = 0; m_hold_val16 = 0; m_hold_bin12 = 0; m_hold_val12 = 0;
        end else if (m_done != 0) begin
            m_done = 0; m_busy = 0;
            m_hold_bin16 = m_exp_bin16; m_hold_val16 = m_exp_val16;
            m_hold_bin12 = m_exp_bin12; m_hold_val12 = m_exp_val12;
        end else if (m_busy == 0) begin
            if (start) begin m_busy = 1; m_clear = 1; end
        end else if (m_clear != 0) begin
            m_clear = 0; m_ready = 1; m_cnt = 0; m_nacc = 0;
        end else if (m_ready != 0) begin
            if (in_valid) begin
                s_mag[m_cnt] = int'(in_mag);
                s_dir[m_cnt] = int'(rom_tab[m_cnt]);
                m_cnt = (m_cnt + 1) % 256;
                m_nacc++;
                if (m_nacc == 256) begin
                    m_ready = 0;
                    m_left = 32;
                    ref_peak(16, m_exp_bin16, m_exp_val16);
                    ref_peak(12, m_exp_bin12, m_exp_val12);
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_seen = 0, t_done = 0;
    int cap_bin16 = -1, cap_val16 = -1, cap_bin12 = -1, cap_val12 = -1;

    always @(negedge clk) begin
        check("busy16", busy16, m_busy);
        check("busy12", busy12, m_busy);
        check("in_ready16", ready16, m_ready);
        check("in_ready12", ready12, m_ready);
        check("rom_addr16", addr16, m_cnt);
        check("rom_addr12", addr12, m_cnt);
        check("done16", done16, m_done);
        check("done12", done12, m_done);
        check("peak_bin16", pbin16, (m_done != 0) ? m_exp_bin16 : m_hold_bin16);
        check("peak_val16", pval16, (m_done != 0) ? m_exp_val16 : m_hold_val16);
        check("peak_bin12", pbin12, (m_done != 0) ? m_exp_bin12 : m_hold_bin12);
        check("peak_val12", pval12, (m_done != 0) ? m_exp_val12 : m_hold_val12);
        if (done16) begin
            done_seen = 1;
            t_done = cyc;
            cap_bin16 = int'(pbin16); cap_val16 = int'(pval16);
            cap_bin12 = int'(pbin12); cap_val12 = int'(pval12);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_default_rom();
        for (int a = 0; a < 256; a++) rom_tab[a] = 5'(((a % 16) - (a / 16) - 1) & 31);
    endtask

    task automatic clear_mags();
        for (int a = 0; a < 256; a++) mag_tab[a] = 8'd0;
    endtask

    task automatic run_window(input int stall_pct, input int abort_at, input bit extra_start);
        int acc, stalls, t0, guard;
        acc = 0; stalls = 0; guard = 0;
        done_seen = 0;
        cap_bin16 = -1; cap_val16 = -1; cap_bin12 = -1; cap_val12 = -1;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'($urandom_range(1));
        in_mag = 8'($urandom_range(255));
        @(posedge clk); #1;
        while (acc < 256 && guard < 5000) begin
            guard++;
            if (abort_at == acc) begin
                rst = 1'b1;
                in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            in_valid = 1'($urandom_range(99) >= stall_pct);
            in_mag = in_valid ? mag_tab[acc] : 8'($urandom_range(255));
            start = extra_start && (acc >= 100) && (acc < 104);
            @(posedge clk); #1;
            if (in_valid) acc++;
            else stalls++;
        end
        check("accept_budget", acc, 256);
        in_valid = 1'b0; start = 1'b0; in_mag = '0;
        guard = 0;
        while (done_seen == 0 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_within_budget", done_seen, 1);
        if (done_seen != 0) check("start_to_done_latency", t_done - t0, 290 + stalls);
        @(posedge clk); #1;
    endtask

    initial begin
        set_default_rom();
        clear_mags();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: all-zero window, no stalls
        run_window(0, -1, 1'b0);
        check("t1_bin16", cap_bin16, 0);
        check("t1_val16", cap_val16, 0);
        check("t1_val12", cap_val12, 0);

        // 2: single magnitude into bin 31
        mag_tab[0] = 8'd200;
        run_window(0, -1, 1'b0);
        check("t2_bin16", cap_bin16, 31);
        check("t2_val16", cap_val16, 200);
        check("t2_bin12", cap_bin12, 31);
        check("t2_model_hold", m_hold_val16, 200);

        // 3: tie between bin 31 and bin 0 -> lowest index
        clear_mags();
        mag_tab[0] = 8'd50;
        mag_tab[1] = 8'd50;
        run_window(0, -1, 1'b0);
        check("t3_bin16", cap_bin16, 0);
        check("t3_val16", cap_val16, 50);

        // 4: stalls
        clear_mags();
        mag_tab[8'h02] = 8'd100;
        mag_tab[8'h12] = 8'd150;
        run_window(30, -1, 1'b0);
        check("t4_bin16", cap_bin16, 0);
        check("t4_val16", cap_val16, 150);

        // 5: saturation at 12 bits plus a start pulse mid-window
        for (int a = 0; a < 256; a++) begin
            rom_tab[a] = 5'(a % 7);
            mag_tab[a] = 8'd255;
        end
        run_window(10, -1, 1'b1);
        check("t5_bin12", cap_bin12, 0);
        check("t5_val12", cap_val12, 4095);
        check("t5_bin16", cap_bin16, 0);
        check("t5_val16", cap_val16, 9435);

        // 6: reset at sample 100 of a full-scale window, then case-2 data
        set_default_rom();
        run_window(5, 100, 1'b0);
        clear_mags();
        mag_tab[0] = 8'd200;
        run_window(0, -1, 1'b0);
        check("t6_bin16", cap_bin16, 31);
        check("t6_val16", cap_val16, 200);
        check("t6_val12", cap_val12, 200);

        // random windows
        for (int w = 0; w < 6; w++) begin
            int mag_max;
            int dir_max;
            mag_max = (w % 2 == 0) ? 255 : 15;
            dir_max = (w % 3 == 0) ? 31 : 3;
            for (int a = 0; a < 256; a++) begin
                rom_tab[a] = 5'($urandom_range(dir_max));
                mag_tab[a] = 8'($urandom_range(mag_max));
            end
            run_window(int'($urandom_range(40)), -1, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
